ts_tx_pacer: RTL and testbench

TS_TX_PACER -- requirements
Module: ts_tx_pacer

---
 rtl/ts_tx_pacer.sv | 134 +++++++++++++
 tb/tb_ts_tx_pacer.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/ts_tx_pacer.sv
// ts_tx_pacer: small TS FIFO that spaces outgoing training sets by a
// speed-dependent interval. The LTSSM lane generator writes TSs into the
// FIFO. One TS is popped every N cycles, where N is 64/32/16/8/4 for
// Gen1..Gen5.
//
// Ports
//   clk          system clock; all logic runs on this clock
//   rst          synchronous active-high reset
//   speed[5:0]   one-hot link speed (bit0=Gen1 .. bit4=Gen5, bit5 reserved)
//   flush        discard everything queued and restart pacing
//   ts_i[127:0]  TS from the lane generator
//   ts_i_vld     ts_i valid this cycle
//   tx_fifo_full FIFO holds DEPTH entries
//   ts_o[127:0]  paced TS; holds its last popped value between pulses
//   ts_o_vld     one-cycle pulse marking a new ts_o
//   fifo_level   current entry count
//   ovf          sticky: a write was dropped because the FIFO was full
module ts_tx_pacer #(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [5:0]             speed,
  input  logic                   flush,
  input  logic [127:0]           ts_i,
  input  logic                   ts_i_vld,
  output logic                   tx_fifo_full,
  output logic [127:0]           ts_o,
  output logic                   ts_o_vld,
  output logic [$clog2(DEPTH):0] fifo_level,
  output logic                   ovf
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

  // Gap reload value is N-1. The pop cycle itself is the first cycle of the
  // interval, so this value makes pulses land exactly N cycles apart.
  function automatic logic [5:0] gap_reload(input logic [5:0] spd);
    case (spd)
      6'b000001: gap_reload = 6'd63;
      6'b000010: gap_reload = 6'd31;
      6'b000100: gap_reload = 6'd15;
      6'b001000: gap_reload = 6'd7;
      6'b010000: gap_reload = 6'd3;
      default:   gap_reload = 6'd63;
    endcase
  endfunction

  logic [127:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic [5:0]    gap_q, gap_d;
  logic [127:0]  ts_q, ts_d;
  logic          vld_q, vld_d;
  logic          ovf_q, ovf_d;
  logic          push, pop, drop;

  always_comb begin
    // Full is judged on the level before the edge. A write that meets a
    // full FIFO is therefore dropped, even when a pop frees a slot on that
    // same edge.
    push = ts_i_vld && !flush && (level_q != FULL_LVL);
    drop = ts_i_vld && !flush && (level_q == FULL_LVL);
    pop  = !flush && (gap_q == 6'd0) && (level_q != '0);

    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    gap_d    = gap_q;
    ts_d     = ts_q;
    vld_d    = 1'b0;
    ovf_d    = ovf_q;

    if (flush) begin
      // The flush leaves ts_o untouched.
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
      gap_d    = 6'd0;
      ovf_d    = 1'b0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({push, pop})
        2'b10:   level_d = level_q + LW'(1);
        2'b01:   level_d = level_q - LW'(1);
        default: level_d = level_q;
      endcase
      if (pop) begin
        ts_d  = mem_q[rd_ptr_q];
        vld_d = 1'b1;
        gap_d = gap_reload(speed);
      end else if (gap_q != 6'd0) begin
        gap_d = gap_q - 6'd1;
      end
      if (drop) ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      gap_q    <= 6'd0;
      ts_q     <= '0;
      vld_q    <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      gap_q    <= gap_d;
      ts_q     <= ts_d;
      vld_q    <= vld_d;
      ovf_q    <= ovf_d;
    end
  end

  // Storage needs no reset. The pointers and the level define what is valid.
  always_ff @(posedge clk) begin
    if (!rst && push) mem_q[wr_ptr_q] <= ts_i;
  end

  assign tx_fifo_full = (level_q == FULL_LVL);
  assign ts_o         = ts_q;
  assign ts_o_vld     = vld_q;
  assign fifo_level   = level_q;
  assign ovf          = ovf_q;

endmodule

// File: tb/tb_ts_tx_pacer.sv
module tb_ts_tx_pacer;

  localparam int DEPTH = 4;
  localparam logic [5:0] GEN1 = 6'b000001;
  localparam logic [5:0] GEN3 = 6'b000100;
  localparam logic [5:0] GEN4 = 6'b001000;
  localparam logic [5:0] GEN5 = 6'b010000;

  logic                   clk = 1'b0;
  logic                   rst;
  logic [5:0]             speed;
  logic                   flush;
  logic [127:0]           ts_i;
  logic                   ts_i_vld;
  logic                   tx_fifo_full;
  logic [127:0]           ts_o;
  logic                   ts_o_vld;
  logic [$clog2(DEPTH):0] fifo_level;
  logic                   ovf;

  ts_tx_pacer #(.DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .speed        (speed),
    .flush        (flush),
    .ts_i         (ts_i),
    .ts_i_vld     (ts_i_vld),
    .tx_fifo_full (tx_fifo_full),
    .ts_o         (ts_o),
    .ts_o_vld     (ts_o_vld),
    .fifo_level   (fifo_level),
    .ovf          (ovf)
  );

  always #5 clk = ~clk;

  int edge_cnt = 0;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  typedef struct {
    logic [127:0] d;
    int           e;
  } exp_t;

  exp_t         exp_q[$];
  logic [127:0] mq[$];
  int           next_ok = 0;
  logic         m_ovf = 1'b0;
  logic [127:0] m_ts = '0;
  bit           chk_en = 1'b0;
  int           checks = 0;
  int           failures = 0;

  function automatic int interval(input logic [5:0] s);
    case (s)
      6'b000001: return 64;
      6'b000010: return 32;
      6'b000100: return 16;
      6'b001000: return 8;
      6'b010000: return 4;
      default:   return 64;
    endcase
  endfunction

  // Reference model: a pop is allowed once the current edge reaches the
  // earliest edge permitted by the last pop. That edge is the last pop plus
  // N, using the speed seen at that pop.
  task automatic step(input logic r, input logic f, input logic v, input logic [5:0] sp);
    logic [127:0] d;
    int           e;
    int           pre;
    exp_t         x;
    d = {$urandom(), $urandom(), $urandom(), $urandom()};
    rst = r; flush = f; ts_i_vld = v; ts_i = d; speed = sp;
    e = edge_cnt;
    if (r) begin
      mq.delete(); next_ok = 0; m_ovf = 1'b0; m_ts = '0;
    end else if (f) begin
      mq.delete(); next_ok = 0; m_ovf = 1'b0;
    end else begin
      pre = mq.size();
      if (pre > 0 && e >= next_ok) begin
        m_ts = mq.pop_front();
        next_ok = e + interval(sp);
        x.d = m_ts; x.e = e;
        exp_q.push_back(x);
      end
      if (v && pre < DEPTH) mq.push_back(d);
      if (v && pre == DEPTH) m_ovf = 1'b1;
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n, input logic [5:0] sp);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, sp);
  endtask

  // Monitor: runs just after every edge and compares the DUT with the model.
  always begin
    exp_t x;
    @(posedge clk);
    #1;
    if (chk_en) begin
      checks++;
      if (ts_o_vld === 1'b1) begin
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_pulse edge=%0d ts_o=%h", edge_cnt - 1, ts_o);
        end else begin
          x = exp_q.pop_front();
          if (x.e != edge_cnt - 1 || ts_o !== x.d) begin
            failures++;
            $display("FAIL pulse edge=%0d ts_o=%h required edge=%0d ts_o=%h",
                     edge_cnt - 1, ts_o, x.e, x.d);
          end
        end
      end else if (ts_o_vld !== 1'b0) begin
        failures++;
        $display("FAIL ts_o_vld_x edge=%0d value=%b", edge_cnt - 1, ts_o_vld);
      end else if (exp_q.size() > 0 && exp_q[0].e <= edge_cnt - 1) begin
        x = exp_q.pop_front();
        failures++;
        $display("FAIL missing_pulse edge=%0d required ts_o=%h", x.e, x.d);
      end

      checks++;
      if ($isunknown(fifo_level) || int'(fifo_level) != mq.size()) begin
        failures++;
        $display("FAIL fifo_level edge=%0d got=%0d required=%0d", edge_cnt - 1, fifo_level, mq.size());
      end
      checks++;
      if (ovf !== m_ovf) begin
        failures++;
        $display("FAIL ovf edge=%0d got=%b required=%b", edge_cnt - 1, ovf, m_ovf);
      end
      checks++;
      if (tx_fifo_full !== (mq.size() == DEPTH)) begin
        failures++;
        $display("FAIL tx_fifo_full edge=%0d got=%b required=%b", edge_cnt - 1, tx_fifo_full, mq.size() == DEPTH);
      end
      checks++;
      if (ts_o !== m_ts) begin
        failures++;
        $display("FAIL ts_o_value edge=%0d got=%h required=%h", edge_cnt - 1, ts_o, m_ts);
      end
    end
  end

  initial begin
    logic [5:0] sp;
    int         r;
    rst = 1'b1; flush = 1'b0; ts_i_vld = 1'b0; ts_i = '0; speed = GEN1;
    @(negedge clk);
    step(1'b1, 1'b0, 1'b0, GEN1);
    chk_en = 1'b1;
    step(1'b1, 1'b0, 1'b0, GEN1);

    // Gen5: two writes, pulses one cycle after the first write and 4 apart
    step(1'b0, 1'b0, 1'b1, GEN5);
    step(1'b0, 1'b0, 1'b1, GEN5);
    idle(8, GEN5);

    // Gen1: five back-to-back writes, the early pop avoids any drop
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b1, GEN1);
    idle(270, GEN1);

    // Gen3: keep writing into a full FIFO, including on pop edges
    step(1'b0, 1'b1, 1'b0, GEN3);
    for (int i = 0; i < 40; i++) step(1'b0, 1'b0, 1'b1, GEN3);
    idle(80, GEN3);

    // Gen1 -> Gen4 switch mid-gap: running gap keeps its 64-cycle length
    step(1'b0, 1'b1, 1'b0, GEN1);
    step(1'b0, 1'b0, 1'b1, GEN1);
    for (int i = 0; i < 24; i++) step(1'b0, 1'b0, i < 2, GEN1);
    idle(80, GEN4);

    // Flush with 3 queued, a concurrent write and ovf set
    step(1'b0, 1'b1, 1'b0, GEN1);
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 1'b1, GEN1);
    idle(70, GEN1);
    step(1'b0, 1'b1, 1'b1, GEN1);
    idle(1, GEN1);
    step(1'b0, 1'b0, 1'b1, GEN1);
    idle(3, GEN1);

    // Reset mid-gap with 2 queued entries
    step(1'b0, 1'b1, 1'b0, GEN1);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, GEN1);
    idle(10, GEN1);
    step(1'b1, 1'b0, 1'b0, GEN1);
    idle(20, GEN1);
    step(1'b0, 1'b0, 1'b1, GEN1);
    idle(5, GEN1);

    // Randomized traffic, including reserved and malformed speed codes
    sp = GEN5;
    for (int i = 0; i < 2500; i++) begin
      if ($urandom_range(0, 39) == 0) begin
        r = $urandom_range(0, 7);
        if (r < 5)       sp = 6'd1 << r;
        else if (r == 5) sp = 6'b100000;
        else if (r == 6) sp = 6'b000000;
        else             sp = 6'($urandom());
      end
      step($urandom_range(0, 199) == 0, $urandom_range(0, 59) == 0,
           $urandom_range(0, 9) < 6, sp);
    end

    idle(300, GEN5);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain pending=%0d required=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
